// File: rtl/wb_pkg.sv
// Shared constants and helpers for the write-back queue.
package wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 4;
  localparam int unsigned WB_DATA_WIDTH = 8;
  localparam int unsigned WB_DEPTH      = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned wb_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One read-port forwarding comparator: the youngest occupied entry whose
// address matches the read address supplies the operand, otherwise the
// register file data passes through.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int unsigned AddrWidth = WB_ADDR_WIDTH,
  parameter int unsigned DataWidth = WB_DATA_WIDTH,
  parameter int unsigned Depth     = WB_DEPTH
) (
  input  logic [AddrWidth-1:0]                rd_addr_i,
  input  logic [DataWidth-1:0]                rf_data_i,
  input  logic [$clog2(Depth)-1:0]            head_i,
  input  logic [$clog2(Depth):0]              count_i,
  input  logic [Depth-1:0][AddrWidth-1:0]     ent_addr_i,
  input  logic [Depth-1:0][DataWidth-1:0]     ent_data_i,
  output logic [DataWidth-1:0]                op_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = wb_cnt_width(Depth);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last hit (youngest) wins.
  always_comb begin
    op_o = rf_data_i;
    idx  = head_i;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = head_i + PtrW'(k);
      if ((CntW'(k) < count_i) && (ent_addr_i[idx] == rd_addr_i)) begin
        op_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue in front of the register file: in-order FIFO that drains
// one entry per cycle into the single write port. Optional operand
// forwarding from pending entries is compiled in when WB_BYPASS_EN is
// defined; otherwise op2/op3 pass the register file read data through.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned DEPTH      = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    wen1,
  output logic [ADDR_WIDTH-1:0]   ad1,
  output logic [DATA_WIDTH-1:0]   din1,
  input  logic [ADDR_WIDTH-1:0]   rd_ad2,
  input  logic [ADDR_WIDTH-1:0]   rd_ad3,
  input  logic [DATA_WIDTH-1:0]   rf_dout2,
  input  logic [DATA_WIDTH-1:0]   rf_dout3,
  output logic [DATA_WIDTH-1:0]   op2,
  output logic [DATA_WIDTH-1:0]   op3,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = wb_cnt_width(DEPTH);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign in_ready = (count_q != CntW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0);

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; reset discards any pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; occupancy comes from head/count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Drain port and status outputs.
  always_comb begin
    wen1  = pop;
    ad1   = addr_q[head_q];
    din1  = data_q[head_q];
    count = count_q;
    empty = (count_q == '0);
  end

`ifdef WB_BYPASS_EN
  wb_fwd_match #(
    .AddrWidth (ADDR_WIDTH),
    .DataWidth (DATA_WIDTH),
    .Depth     (DEPTH)
  ) u_fwd2 (
    .rd_addr_i  (rd_ad2),
    .rf_data_i  (rf_dout2),
    .head_i     (head_q),
    .count_i    (count_q),
    .ent_addr_i (addr_q),
    .ent_data_i (data_q),
    .op_o       (op2)
  );

  wb_fwd_match #(
    .AddrWidth (ADDR_WIDTH),
    .DataWidth (DATA_WIDTH),
    .Depth     (DEPTH)
  ) u_fwd3 (
    .rd_addr_i  (rd_ad3),
    .rf_data_i  (rf_dout3),
    .head_i     (head_q),
    .count_i    (count_q),
    .ent_addr_i (addr_q),
    .ent_data_i (data_q),
    .op_o       (op3)
  );
`else
  // Read addresses only matter to the register file in this build.
  logic unused_rd_ad;
  assign unused_rd_ad = ^{rd_ad2, rd_ad3};

  assign op2 = rf_dout2;
  assign op3 = rf_dout3;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios with literal
// expectations plus a randomized phase, all checked against a queue-based
// reference model and a bench-side register file.
module tb_wb_queue;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned DP = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wen1;
  logic [AW-1:0] ad1;
  logic [DW-1:0] din1;
  logic [AW-1:0] rd_ad2, rd_ad3;
  logic [DW-1:0] rf_dout2, rf_dout3;
  logic [DW-1:0] op2, op3;
  logic [2:0]    count;
  logic          empty;

  int vectors = 0;
  int miscompares = 0;

  // Bench register file, written by the DUT drain port.
  logic [DW-1:0] rf_q [16];
  assign rf_dout2 = rf_q[rd_ad2];
  assign rf_dout3 = rf_q[rd_ad3];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t mq[$];

  wb_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .wen1     (wen1),
    .ad1      (ad1),
    .din1     (din1),
    .rd_ad2   (rd_ad2),
    .rd_ad3   (rd_ad3),
    .rf_dout2 (rf_dout2),
    .rf_dout3 (rf_dout3),
    .op2      (op2),
    .op3      (op3),
    .count    (count),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected operand: youngest pending write to rd (when forwarding is built in).
  function automatic logic [DW-1:0] exp_op(input logic [AW-1:0] rd, input logic [DW-1:0] rf);
`ifdef WB_BYPASS_EN
    for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
      if (mq[i].a == rd) return mq[i].d;
    end
`endif
    return rf;
  endfunction

  // Register file capture.
  always @(posedge clk) begin
    if (wen1) rf_q[ad1] <= din1;
  end

  // Reference model: one pop per cycle when occupied, push when not full.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      logic do_push;
      ent_t e;
      do_push = in_valid && (mq.size() < DP);
      e.a = in_addr;
      e.d = in_data;
      if (mq.size() != 0) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  end

  always @(negedge rst_n) mq.delete();

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("wen1", wen1, (mq.size() != 0));
    chk("count", count, mq.size());
    chk("empty", empty, (mq.size() == 0));
    chk("in_ready", in_ready, (mq.size() != DP));
    if (mq.size() != 0) begin
      chk("ad1", ad1, mq[0].a);
      chk("din1", din1, mq[0].d);
    end
    chk("op2", op2, exp_op(rd_ad2, rf_dout2));
    chk("op3", op3, exp_op(rd_ad3, rf_dout3));
  end

  logic [DW-1:0] exp_byp;

  initial begin
    for (int i = 0; i < 16; i++) rf_q[i] = '0;
    rf_q[9] = 8'hEE;
    rst_n = 1'b0; in_valid = 1'b1; in_addr = 4'd3; in_data = 8'h5A;
    rd_ad2 = '0; rd_ad3 = '0;

    // Reset with in_valid held high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen1", wen1, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    cyc(); rst_n = 1'b1;
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("first_wen1", wen1, 1'b1);
    chk("first_ad1", ad1, 4'd3);
    chk("first_din1", din1, 8'h5A);
    cyc();
    @(negedge clk);
    chk("first_rf3", rf_q[3], 8'h5A);

    // Back-to-back pushes drain in order.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_addr = AW'(i); in_data = DW'(i * 16);
      cyc();
      @(negedge clk);
      chk("fill_ad1", ad1, i);
      chk("fill_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("fill_drained", count, 3'd0);

    // Same-address ordering.
    in_valid = 1'b1; in_addr = 4'd5; in_data = 8'h11;
    cyc(); in_data = 8'h22;
    @(negedge clk);
    chk("same_din1_a", din1, 8'h11);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("same_din1_b", din1, 8'h22);
    cyc();
    @(negedge clk);
    chk("same_rf5", rf_q[5], 8'h22);

    // Forwarding hit on port 2, miss on port 3.
    rd_ad2 = 4'd7; rd_ad3 = 4'd9;
    in_valid = 1'b1; in_addr = 4'd7; in_data = 8'h33;
    cyc(); in_data = 8'h44;
`ifdef WB_BYPASS_EN
    exp_byp = 8'h33;
`else
    exp_byp = 8'h00;
`endif
    @(negedge clk);
    chk("fwd_op2_a", op2, exp_byp);
    chk("fwd_op3_miss", op3, 8'hEE);
    cyc(); in_valid = 1'b0;
`ifdef WB_BYPASS_EN
    exp_byp = 8'h44;
`else
    exp_byp = 8'h33;
`endif
    @(negedge clk);
    chk("fwd_op2_b", op2, exp_byp);
    cyc();
    @(negedge clk);
    chk("fwd_op2_after", op2, 8'h44);
    chk("fwd_rf7", rf_q[7], 8'h44);

    // Asynchronous reset between edges discards the pending write.
    in_valid = 1'b1; in_addr = 4'd12; in_data = 8'hC3;
    cyc(); in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 3'd0);
    chk("midrst_wen1", wen1, 1'b0);
    #1 rst_n = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("midrst_rf12", rf_q[12], 8'h00);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = AW'($urandom_range(0, 15));
      in_data  = DW'($urandom_range(0, 255));
      rd_ad2   = AW'($urandom_range(0, 15));
      rd_ad3   = ($urandom_range(0, 1) != 0) ? rd_ad2 : AW'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
